// File: rtl/sap_bus_pkg.sv
`default_nettype none
// ============================================================================
// Package     : sap_bus_pkg
// Description : Shared widths and FSM state encoding for the 16-source byte arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package sap_bus_pkg;

    localparam int DATA_W    = 8;
    localparam int N_SRC     = 16;
    localparam int SRC_IDX_W = 4;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

endpackage : sap_bus_pkg
`default_nettype wire

// File: rtl/rr_pick16.sv
`default_nettype none
// ============================================================================
// Module      : rr_pick16
// Description : Combinational rotating-priority picker: first set req bit at
//               ptr, ptr+1, ... with mod-16 wrap.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_pick16
    import sap_bus_pkg::*;
(
    input  logic [N_SRC-1:0]     req,
    input  logic [SRC_IDX_W-1:0] ptr,
    output logic                 any,
    output logic [SRC_IDX_W-1:0] idx
);

    logic [SRC_IDX_W-1:0] w_cand;

    // Scan from the farthest offset down so the nearest-to-ptr request is the
    // last assignment and therefore wins.
    always_comb begin
        any    = 1'b0;
        idx    = '0;
        w_cand = '0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            w_cand = ptr + SRC_IDX_W'(i);
            if (req[w_cand]) begin
                any = 1'b1;
                idx = w_cand;
            end
        end
    end

endmodule : rr_pick16
`default_nettype wire

// File: rtl/mux_arb_16line_8bit.sv
`default_nettype none
// ============================================================================
// Module      : mux_arb_16line_8bit
// Description : 16-source round-robin byte multiplexer with a registered,
//               valid/ready output and one-hot per-source acknowledge.
// Revision    : 1.0 - initial release
// ============================================================================
module mux_arb_16line_8bit #(
    parameter int DATA_W = 8,
    parameter int N_SRC  = 16
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [N_SRC*DATA_W-1:0]          in_data,
    input  logic [N_SRC-1:0]                 req,
    output logic [N_SRC-1:0]                 ack,
    output logic [DATA_W-1:0]                out,
    output logic [sap_bus_pkg::SRC_IDX_W-1:0] out_src,
    output logic                             out_valid,
    input  logic                             out_ready
);

    import sap_bus_pkg::*;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [SRC_IDX_W-1:0] r_ptr;
    logic [DATA_W-1:0]    r_out;
    logic [SRC_IDX_W-1:0] r_out_src;
    logic                 w_any;
    logic [SRC_IDX_W-1:0] w_idx;
    logic                 w_grant;
    logic                 w_xfer;

    rr_pick16 u_pick (
        .req (req),
        .ptr (r_ptr),
        .any (w_any),
        .idx (w_idx)
    );

    assign w_grant = (r_state == IDLE) && w_any;
    assign w_xfer  = (r_state == HOLD) && out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_any)     w_state_nxt = HOLD;
            HOLD:    if (out_ready) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Capture only on the grant edge; the held byte is immune to input changes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out     <= '0;
            r_out_src <= '0;
            r_ptr     <= '0;
        end else begin
            if (w_grant) begin
                r_out     <= in_data[int'(w_idx)*DATA_W +: DATA_W];
                r_out_src <= w_idx;
            end
            if (w_xfer) begin
                r_ptr <= r_out_src + SRC_IDX_W'(1);
            end
        end
    end

    always_comb begin
        ack = '0;
        if (w_xfer) begin
            ack[r_out_src] = 1'b1;
        end
    end

    assign out       = r_out;
    assign out_src   = r_out_src;
    assign out_valid = (r_state == HOLD);

endmodule : mux_arb_16line_8bit
`default_nettype wire

// File: tb/tb_mux_arb_16line_8bit.sv
`default_nettype none
// ============================================================================
// Module      : tb_mux_arb_16line_8bit
// Description : Directed self-checking bench for the 16-source byte arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mux_arb_16line_8bit;

    logic         clk;
    logic         rst_n;
    logic [127:0] in_data;
    logic [15:0]  req;
    logic [15:0]  ack;
    logic [7:0]   out;
    logic [3:0]   out_src;
    logic         out_valid;
    logic         out_ready;

    int n_checks;
    int n_pass;

    mux_arb_16line_8bit #(
        .DATA_W (8),
        .N_SRC  (16)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .req       (req),
        .ack       (ack),
        .out       (out),
        .out_src   (out_src),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic set_byte(input int k, input logic [7:0] v);
        in_data[k*8 +: 8] = v;
    endtask

    // Expect a held byte with out_ready high: ack is the one-hot of the source.
    task automatic expect_byte(input string tag, input logic [7:0] b, input logic [3:0] s);
        logic [15:0] oh;
        oh = 16'h0001 << s;
        check({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
        check({tag, "_out"}, {24'd0, out}, {24'd0, b});
        check({tag, "_src"}, {28'd0, out_src}, {28'd0, s});
        check({tag, "_ack"}, {16'd0, ack}, {16'd0, oh});
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        n_checks  = 0;
        n_pass    = 0;
        rst_n     = 1'b0;
        req       = '0;
        in_data   = '0;
        out_ready = 1'b0;

        // Reset values before any clock edge
        #1;
        check("rst_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out", {24'd0, out}, 32'h00);
        check("rst_src", {28'd0, out_src}, 32'd0);
        check("rst_ack", {16'd0, ack}, 32'd0);
        tick();
        tick();
        rst_n = 1'b1;

        // Idle with no requests, out_ready high must not ack
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("idle_valid", {31'd0, out_valid}, 32'd0);
            check("idle_ack", {16'd0, ack}, 32'd0);
        end
        check("idle_out", {24'd0, out}, 32'h00);

        // Single source 4
        set_byte(4, 8'hA5);
        req = 16'h0010;
        tick();
        expect_byte("s4", 8'hA5, 4'd4);
        tick();
        req = 16'h0000;
        check("s4_done_valid", {31'd0, out_valid}, 32'd0);
        check("s4_done_ack", {16'd0, ack}, 32'd0);
        tick();
        check("s4_idle_valid", {31'd0, out_valid}, 32'd0);

        // Reset between edges to bring ptr back to 0
        #1 rst_n = 1'b0;
        #1 rst_n = 1'b1;

        // All sources requesting: 0..15,0,1 one byte every 2 cycles
        for (int k = 0; k < 16; k++) set_byte(k, 8'(k));
        req = 16'hFFFF;
        for (int n = 0; n < 18; n++) begin
            tick();
            expect_byte("rr", 8'(n % 16), 4'(n % 16));
            tick();
            check("rr_gap_valid", {31'd0, out_valid}, 32'd0);
            check("rr_gap_ack", {16'd0, ack}, 32'd0);
        end
        req = 16'h0000;
        tick();

        // Move ptr to 15 via a source-14 transfer, then wrap 15 -> 0
        set_byte(14, 8'hE1);
        req = 16'h4000;
        tick();
        expect_byte("s14", 8'hE1, 4'd14);
        tick();
        set_byte(15, 8'hF0);
        set_byte(0, 8'h0F);
        req = 16'h8001;
        tick();
        expect_byte("wrap15", 8'hF0, 4'd15);
        tick();
        tick();
        expect_byte("wrap0", 8'h0F, 4'd0);
        tick();
        req = 16'h0000;
        tick();

        // Hold stability under back-pressure and input churn
        out_ready = 1'b0;
        set_byte(2, 8'h3C);
        req = 16'h0004;
        tick();
        set_byte(2, 8'h77);
        set_byte(9, 8'h99);
        req = 16'h0204;
        for (int i = 0; i < 5; i++) begin
            check("hold_valid", {31'd0, out_valid}, 32'd1);
            check("hold_out", {24'd0, out}, 32'h3C);
            check("hold_src", {28'd0, out_src}, 32'd2);
            check("hold_ack", {16'd0, ack}, 32'd0);
            tick();
        end
        out_ready = 1'b1;
        #1;
        expect_byte("hold_rel", 8'h3C, 4'd2);
        tick();
        req = 16'h0200;
        tick();
        expect_byte("s9", 8'h99, 4'd9);
        tick();
        req = 16'h0000;
        tick();

        // Asynchronous reset mid-HOLD abandons the byte; source re-wins after
        out_ready = 1'b0;
        set_byte(7, 8'h5A);
        req = 16'h0080;
        tick();
        check("pre_rst_valid", {31'd0, out_valid}, 32'd1);
        #1 rst_n = 1'b0;
        #1;
        check("arst_valid", {31'd0, out_valid}, 32'd0);
        check("arst_out", {24'd0, out}, 32'h00);
        check("arst_src", {28'd0, out_src}, 32'd0);
        out_ready = 1'b1;
        #1;
        check("arst_ack", {16'd0, ack}, 32'd0);
        #1 rst_n = 1'b1;
        tick();
        expect_byte("rewin", 8'h5A, 4'd7);
        tick();
        req = 16'h0000;
        check("end_valid", {31'd0, out_valid}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_mux_arb_16line_8bit
`default_nettype wire
